memshare_regfile_loader: RTL and testbench
==========================================

MEMSHARE_REGFILE_LOADER -- requirements
Module: memshare_regfile_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, Type-0 register-file page-address width.
REQ-002 SHALL have parameter PAGE_W, default 7, Type-0 page (register) width.
REQ-003 SHALL have parameter PAGE_NUM, default 64, number of Type-0 pages; PAGE_NUM <= 2**ADDR_W.
REQ-004 SHALL have port sys_clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start_i  input  1  single-cycle request to begin a load burst.
REQ-007 SHALL have port base_addr_i  input  ADDR_W  first page written, sampled with start_i.
REQ-008 SHALL have port page_cnt_i  input  ADDR_W+1  pages in burst, sampled with start_i, legal 1..PAGE_NUM.
REQ-009 SHALL have port cfg_data_i  input  PAGE_W  L1PA_SPR/PSRA/START/END page word.
REQ-010 SHALL have port cfg_valid_i  input  1  cfg_data_i valid.
REQ-011 SHALL have port cfg_ready_o  output  1  loader accepts a beat.
REQ-012 SHALL have port regType0_waddr_o  output  ADDR_W  write address to the memShare control wrapper regFile port.
REQ-013 SHALL have port regType0_wdata_o  output  PAGE_W  write data to the same port.
REQ-014 SHALL have port regType0_we_o  output  1  write strobe, one cycle per page.
REQ-015 SHALL have port busy_o  output  1  state is LOAD or DONE.
REQ-016 SHALL have port done_o  output  1  one-cycle pulse at burst completion.
REQ-017 SHALL have port err_o  output  1  sticky error flag.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-019 IDLE: start_i with legal page_cnt_i SHALL latch base/count, clear index and err_o, enter LOAD next cycle.
REQ-020 IDLE: start_i with page_cnt_i = 0 or > PAGE_NUM SHALL set err_o and remain IDLE.
REQ-021 cfg_ready_o SHALL be 1 only in LOAD; a beat is accepted when cfg_valid_i & cfg_ready_o.
REQ-022 Accepted beat in cycle N SHALL produce regType0_we_o=1 in cycle N+1 with waddr = (base + index) mod PAGE_NUM and wdata = beat data (latency 1).
REQ-023 Address wrap: base + index >= PAGE_NUM SHALL wrap to page 0 upward; no write outside 0..PAGE_NUM-1.
REQ-024 index SHALL increment per accepted beat; cfg_valid_i=0 stalls with no write and no index change.
REQ-025 Accepting the beat with index = count-1 SHALL enter DONE; cfg_ready_o=0 from the next cycle.
REQ-026 DONE SHALL last exactly one cycle, assert done_o (coincident with the last write strobe), then return to IDLE.
REQ-027 start_i in LOAD or DONE SHALL be ignored for the burst and set err_o.
REQ-028 regType0_we_o SHALL be 0 whenever no beat was accepted in the previous cycle.

Reset
REQ-029 rstn=0 SHALL force IDLE, index 0, cfg_ready_o=0, regType0_we_o=0, regType0_waddr_o=0, regType0_wdata_o=0, busy_o=0, done_o=0, err_o=0.
REQ-030 Reset mid-burst SHALL abort without done_o; a write registered in the reset cycle SHALL NOT be issued.

Configuration
REQ-031 With MEMSHARE_LOADER_PARITY_EN defined, SHALL add input cfg_parity_i (1 bit, even parity over cfg_data_i); a mismatching beat is accepted, not written (we stays 0), index still advances, err_o set.
REQ-032 Without MEMSHARE_LOADER_PARITY_EN, cfg_parity_i SHALL NOT exist and every accepted beat is written.

Structure
REQ-033 State enum and default ADDR_W/PAGE_W/PAGE_NUM constants SHALL reside in memShare_config_pkg, aligned with L1PA_REGFILE_ADDR_WIDTH, L1PA_REGFILE_PAGE_WIDTH, L1PA_REGFILE_PAGE_NUM.
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 start base=0, cnt=4, data 0x11..0x14 back-to-back -> we at pages 0..3 one cycle after each accept, done_o with page-3 write, 6 cycles start-to-IDLE.
REQ-036 base=62, cnt=4 -> writes to pages 62,63,0,1; no address >= 64.
REQ-037 cnt=3 with cfg_valid_i gap of 2 cycles after beat 1 -> no we during gap, 3 writes total, single done_o.
REQ-038 start with cnt=0, then cnt=65 -> err_o=1, busy_o=0, no writes; next legal start clears err_o.
REQ-039 start_i mid-burst (cnt=8 after 3 beats) -> err_o=1, burst completes 8 writes unchanged.
REQ-040 rstn=0 after 2 of 5 beats -> all outputs 0 next cycle, no done_o; with MEMSHARE_LOADER_PARITY_EN, bad parity on beat 2 of 3 -> pages 0,2 written only, err_o=1.

Source files
------------

// File: rtl/memshare_regfile_loader_pkg.sv
// memShare configuration package: Type-0 regfile geometry and loader states.
// Shared by the loader interface and the loader itself.
package memShare_config_pkg;

  localparam int L1PA_REGFILE_ADDR_WIDTH = 6;
  localparam int L1PA_REGFILE_PAGE_WIDTH = 7;
  localparam int L1PA_REGFILE_PAGE_NUM   = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/memshare_regfile_loader_if.sv
// Config beat stream in, Type-0 regfile write port out.
// MEMSHARE_LOADER_PARITY_EN adds the even-parity bit cfg_parity_i.
interface memshare_regfile_loader_if
  import memShare_config_pkg::*;
#(
  parameter int ADDR_W = L1PA_REGFILE_ADDR_WIDTH,
  parameter int PAGE_W = L1PA_REGFILE_PAGE_WIDTH
);
  logic [PAGE_W-1:0] cfg_data_i;
  logic              cfg_valid_i;
  logic              cfg_ready_o;
`ifdef MEMSHARE_LOADER_PARITY_EN
  logic              cfg_parity_i;
`endif
  logic [ADDR_W-1:0] regType0_waddr_o;
  logic [PAGE_W-1:0] regType0_wdata_o;
  logic              regType0_we_o;

`ifdef MEMSHARE_LOADER_PARITY_EN
  modport master (
    input  cfg_data_i, cfg_valid_i, cfg_parity_i,
    output cfg_ready_o,
    output regType0_waddr_o, regType0_wdata_o, regType0_we_o
  );
  modport slave (
    output cfg_data_i, cfg_valid_i, cfg_parity_i,
    input  cfg_ready_o,
    input  regType0_waddr_o, regType0_wdata_o, regType0_we_o
  );
`else
  modport master (
    input  cfg_data_i, cfg_valid_i,
    output cfg_ready_o,
    output regType0_waddr_o, regType0_wdata_o, regType0_we_o
  );
  modport slave (
    output cfg_data_i, cfg_valid_i,
    input  cfg_ready_o,
    input  regType0_waddr_o, regType0_wdata_o, regType0_we_o
  );
`endif

endinterface

// File: rtl/memshare_regfile_loader.sv
// Burst loader of Type-0 regfile pages; optional beat parity check
// enabled by MEMSHARE_LOADER_PARITY_EN.
module memshare_regfile_loader
  import memShare_config_pkg::*;
#(
  parameter int ADDR_W   = L1PA_REGFILE_ADDR_WIDTH,
  parameter int PAGE_W   = L1PA_REGFILE_PAGE_WIDTH,
  parameter int PAGE_NUM = L1PA_REGFILE_PAGE_NUM
) (
  input  logic                sys_clk,
  input  logic                rstn,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [ADDR_W:0]     page_cnt_i,
  memshare_regfile_loader_if.master bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam logic [ADDR_W:0]   PN   = (ADDR_W+1)'(PAGE_NUM);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PAGE_NUM - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   cnt_q, idx_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [PAGE_W-1:0] wdata_q;
  logic              we_q;
  logic              err_q;
  logic              accept;
  logic              legal;
  logic              par_ok;

  assign legal  = (page_cnt_i != '0) && (page_cnt_i <= PN);
  assign accept = (state_q == LOAD) && bus.cfg_valid_i;

`ifdef MEMSHARE_LOADER_PARITY_EN
  assign par_ok = (bus.cfg_parity_i == ^bus.cfg_data_i);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge sys_clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i && legal) state_d = LOAD;
      LOAD: if (accept && (idx_q + (ADDR_W+1)'(1) == cnt_q))
              state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= accept && par_ok;
      if (accept) begin
        waddr_q <= ptr_q;
        wdata_q <= bus.cfg_data_i;
        idx_q   <= idx_q + (ADDR_W+1)'(1);
        ptr_q   <= (ptr_q == LAST) ? '0 : ptr_q + ADDR_W'(1);
        if (!par_ok) err_q <= 1'b1;
      end
      // a start outside IDLE never restarts the burst, it only flags
      if (start_i) begin
        if (state_q != IDLE) begin
          err_q <= 1'b1;
        end else if (legal) begin
          cnt_q <= page_cnt_i;
          idx_q <= '0;
          ptr_q <= ADDR_W'({1'b0, base_addr_i} % PN);
          err_q <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.cfg_ready_o      = (state_q == LOAD);
  assign bus.regType0_we_o    = we_q;
  assign bus.regType0_waddr_o = waddr_q;
  assign bus.regType0_wdata_o = wdata_q;
  assign busy_o               = (state_q != IDLE);
  assign done_o               = (state_q == DONE);
  assign err_o                = err_q;

endmodule

// File: tb/tb_memshare_regfile_loader.sv
// Bench for memshare_regfile_loader: directed bursts with literal checks
// plus randomized bursts against a per-cycle behavioural model.
module tb_memshare_regfile_loader;

  localparam int ADDR_W   = 6;
  localparam int PAGE_W   = 7;
  localparam int PAGE_NUM = 64;

  logic              sys_clk = 1'b0;
  logic              rstn    = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [ADDR_W:0]   page_cnt_i  = '0;
  logic              busy_o, done_o, err_o;

  memshare_regfile_loader_if #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W)) bus ();

  memshare_regfile_loader dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .page_cnt_i  (page_cnt_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // behavioural model: phase 0 idle, 1 loading, 2 done
  int m_phase = 0, m_idx = 0, m_cnt = 0, m_base = 0;
  int m_waddr = 0, m_wdata = 0;
  bit m_we = 0, m_err = 0;
  bit m_acc, m_pok;
  int m_next;

  always @(posedge sys_clk) begin
    if (!rstn) begin
      m_phase = 0; m_idx = 0; m_err = 0;
      m_we = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      m_acc = (m_phase == 1) && (bus.cfg_valid_i === 1'b1);
      m_pok = 1'b1;
`ifdef MEMSHARE_LOADER_PARITY_EN
      m_pok = ((^{bus.cfg_data_i, bus.cfg_parity_i}) == 1'b0);
`endif
      m_next = m_phase;
      m_we = m_acc && m_pok;
      if (m_acc) begin
        m_waddr = (m_base + m_idx) % PAGE_NUM;
        m_wdata = int'(bus.cfg_data_i);
        if (!m_pok) m_err = 1;
        m_idx++;
        if (m_idx == m_cnt) m_next = 2;
      end
      if (m_phase == 2) m_next = 0;
      if (start_i) begin
        if (m_phase != 0) m_err = 1;
        else if (page_cnt_i >= 1 && int'(page_cnt_i) <= PAGE_NUM) begin
          m_base = int'(base_addr_i); m_cnt = int'(page_cnt_i);
          m_idx = 0; m_err = 0; m_next = 1;
        end else m_err = 1;
      end
      m_phase = m_next;
    end
  end

  logic [4:0] exp_v, act_v;
  always @(negedge sys_clk) begin
    if (chk_en) begin
      exp_v = {m_phase == 1, m_we, m_phase != 0, m_phase == 2, m_err};
      act_v = {bus.cfg_ready_o, bus.regType0_we_o, busy_o, done_o, err_o};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_ctrl t=%0t ready/we/busy/done/err got %b want %b",
                 $time, act_v, exp_v);
      end
      if (m_we) begin
        checks++;
        if (bus.regType0_waddr_o !== ADDR_W'(m_waddr) ||
            bus.regType0_wdata_o !== PAGE_W'(m_wdata)) begin
          errors++;
          $display("FAIL cycle_wr t=%0t addr/data got %0d/%h want %0d/%h",
                   $time, bus.regType0_waddr_o, bus.regType0_wdata_o,
                   m_waddr, m_wdata);
        end
      end
    end
  end

  int log_a[$];
  int log_d[$];
  int done_cnt = 0;
  always @(negedge sys_clk) begin
    if (bus.regType0_we_o === 1'b1) begin
      log_a.push_back(int'(bus.regType0_waddr_o));
      log_d.push_back(int'(bus.regType0_wdata_o));
    end
    if (done_o === 1'b1) done_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clr_log();
    log_a.delete();
    log_d.delete();
    done_cnt = 0;
  endtask

  task automatic set_beat(input bit v, input int d, input bit bad);
    bus.cfg_valid_i = v;
    bus.cfg_data_i  = PAGE_W'(d);
`ifdef MEMSHARE_LOADER_PARITY_EN
    bus.cfg_parity_i = (^bus.cfg_data_i) ^ bad;
`else
    if (bad) bus.cfg_valid_i = v;
`endif
  endtask

  task automatic do_start(input int b, input int c);
    start_i = 1'b1;
    base_addr_i = ADDR_W'(b);
    page_cnt_i  = (ADDR_W+1)'(c);
    tick();
    start_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, int'(bus.cfg_ready_o), 0);
    chk({name, "_we"},    int'(bus.regType0_we_o), 0);
    chk({name, "_waddr"}, int'(bus.regType0_waddr_o), 0);
    chk({name, "_wdata"}, int'(bus.regType0_wdata_o), 0);
    chk({name, "_busy"},  int'(busy_o), 0);
    chk({name, "_done"},  int'(done_o), 0);
    chk({name, "_err"},   int'(err_o), 0);
  endtask

  task automatic send_seq(input int n, input int d0);
    for (int k = 0; k < n; k++) begin
      set_beat(1'b1, d0 + k, 1'b0);
      tick();
    end
    set_beat(1'b0, 0, 1'b0);
  endtask

  int n;
  int c;
  bit bad;

  initial begin
    set_beat(1'b0, 0, 1'b0);
    tick();
    tick();
    chk_all_zero("reset");
    rstn = 1'b1;
    chk_en = 1'b1;
    tick();

    // back-to-back burst, timing pinned by literals
    clr_log();
    do_start(0, 4);
    for (int k = 0; k < 4; k++) begin
      set_beat(1'b1, 'h11 + k, 1'b0);
      tick();
    end
    set_beat(1'b0, 0, 1'b0);
    chk("b2b_done", int'(done_o), 1);
    chk("b2b_last_we", int'(bus.regType0_we_o), 1);
    chk("b2b_last_addr", int'(bus.regType0_waddr_o), 3);
    chk("b2b_last_data", int'(bus.regType0_wdata_o), 'h14);
    tick();
    chk("b2b_idle_at6", int'(busy_o), 0);
    chk("b2b_nwrites", log_a.size(), 4);
    for (int k = 0; k < 4 && k < log_a.size(); k++) begin
      chk("b2b_addr", log_a[k], k);
      chk("b2b_data", log_d[k], 'h11 + k);
    end
    chk("b2b_model_addr", m_waddr, 3);

    // wrap at the top of the page space
    clr_log();
    do_start(62, 4);
    send_seq(4, 'h20);
    tick();
    chk("wrap_nwrites", log_a.size(), 4);
    if (log_a.size() == 4) begin
      chk("wrap_a0", log_a[0], 62);
      chk("wrap_a1", log_a[1], 63);
      chk("wrap_a2", log_a[2], 0);
      chk("wrap_a3", log_a[3], 1);
    end

    // valid gap of two cycles after beat 1
    clr_log();
    do_start(10, 3);
    send_seq(1, 'h30);
    tick();
    tick();
    send_seq(2, 'h31);
    tick();
    chk("gap_nwrites", log_a.size(), 3);
    chk("gap_done", done_cnt, 1);

    // illegal counts, then a legal start clears the error
    clr_log();
    do_start(0, 0);
    chk("cnt0_err", int'(err_o), 1);
    chk("cnt0_busy", int'(busy_o), 0);
    do_start(0, 65);
    chk("cnt65_err", int'(err_o), 1);
    chk("cnt65_busy", int'(busy_o), 0);
    tick();
    chk("illegal_nwrites", log_a.size(), 0);
    do_start(5, 1);
    chk("legal_clr_err", int'(err_o), 0);
    send_seq(1, 'h40);
    tick();

    // start mid-burst is flagged and ignored
    clr_log();
    do_start(20, 8);
    send_seq(3, 'h50);
    start_i = 1'b1;
    base_addr_i = '0;
    page_cnt_i = 2;
    tick();
    start_i = 1'b0;
    send_seq(5, 'h53);
    tick();
    chk("mid_err", int'(err_o), 1);
    chk("mid_nwrites", log_a.size(), 8);
    for (int k = 0; k < 8 && k < log_a.size(); k++)
      chk("mid_addr", log_a[k], 20 + k);

    // reset after two of five beats
    clr_log();
    do_start(0, 5);
    send_seq(2, 'h60);
    set_beat(1'b1, 'h62, 1'b0);
    rstn = 1'b0;
    tick();
    set_beat(1'b0, 0, 1'b0);
    chk_all_zero("midrst");
    rstn = 1'b1;
    tick();
    tick();
    chk("midrst_done", done_cnt, 0);
    chk("midrst_nwrites", log_a.size(), 2);

`ifdef MEMSHARE_LOADER_PARITY_EN
    clr_log();
    do_start(0, 3);
    set_beat(1'b1, 'h70, 1'b0);
    tick();
    set_beat(1'b1, 'h71, 1'b1);
    tick();
    set_beat(1'b1, 'h72, 1'b0);
    tick();
    set_beat(1'b0, 0, 1'b0);
    tick();
    chk("par_nwrites", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("par_a0", log_a[0], 0);
      chk("par_a1", log_a[1], 2);
    end
    chk("par_err", int'(err_o), 1);
`endif

    // randomized bursts against the model
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(7) == 0)
        c = ($urandom_range(1) == 0) ? 0 : $urandom_range(127, 65);
      else
        c = $urandom_range(PAGE_NUM, 1);
      do_start($urandom_range(63), c);
      n = 0;
      while (busy_o === 1'b1 && n < 500) begin
        bad = ($urandom_range(9) == 0);
        set_beat($urandom_range(3) != 0, $urandom_range(127), bad);
        start_i = ($urandom_range(19) == 0);
        tick();
        start_i = 1'b0;
        n++;
      end
      set_beat(1'b0, 0, 1'b0);
      chk("rand_burst_ends", int'(n < 500), 1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
